// File: rtl/ppu_pixel_output.sv
// PPU pixel output stage.
// Captures the mixer's left/right colour pair once per 4-cycle dot slot. It applies
// master brightness and forced blank, then buffers the pairs in a small FIFO. A
// valid/ready serializer emits the pairs as a pixel stream, tagged with line and
// frame starts. A FIFO overflow sets a sticky flag.
// Optional feature macro: PIXEL_OUT_CRC_EN adds a per-frame CRC-16-CCITT of the
// emitted pixels on frame_crc. Without the macro, frame_crc is tied to zero.
module ppu_pixel_output #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LINE_PIXELS = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  step,
    input  logic        pixel_active,
    input  logic        line_start,
    input  logic        frame_start,
    input  logic [14:0] color_left,
    input  logic [14:0] color_right,
    input  logic [3:0]  brightness,
    input  logic        force_blank,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_color,
    output logic [8:0]  out_hpos,
    output logic        out_sol,
    output logic        out_sof,
    output logic        out_line_end,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic [15:0] frame_crc
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [8:0]  HPOS_LAST = 9'(LINE_PIXELS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLeft,
        StRight
    } ser_state_e;

    // Per-channel master brightness: (c * (b + 1)) >> 4. Forced blank gives black.
    function automatic logic [14:0] apply_brightness(input logic [14:0] c,
                                                     input logic [3:0]  b,
                                                     input logic        blank);
        logic [14:0] res;
        logic [4:0]  b_inc;
        logic [8:0]  prod;
        res   = 15'h0;
        b_inc = {1'b0, b} + 5'd1;
        for (int ch = 0; ch < 3; ch++) begin
            prod = {4'd0, c[ch*5 +: 5]} * {4'd0, b_inc};
            res[ch*5 +: 5] = prod[8:4];
        end
        return blank ? 15'h0 : res;
    endfunction

    // ------------------------------------------------------------------
    // S1: capture
    // ------------------------------------------------------------------
    logic        capture;
    logic        pend_sol_q, pend_sof_q;
    logic        s1_valid_q;
    logic [14:0] s1_left_q, s1_right_q;
    logic [3:0]  s1_bright_q;
    logic        s1_blank_q;
    logic        s1_sol_q, s1_sof_q;

    // step==0 is the first slot after the mixer has updated its colour outputs.
    assign capture = (step == 2'h0) && pixel_active;

    // Pending start flags. A pulse in the capture cycle goes straight into that capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_sol_q <= 1'b0;
            pend_sof_q <= 1'b0;
        end else if (capture) begin
            pend_sol_q <= 1'b0;
            pend_sof_q <= 1'b0;
        end else begin
            pend_sol_q <= pend_sol_q | line_start;
            pend_sof_q <= pend_sof_q | frame_start;
        end
    end

    // Capture register for the colour pair and its per-dot controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_left_q   <= 15'h0;
            s1_right_q  <= 15'h0;
            s1_bright_q <= 4'h0;
            s1_blank_q  <= 1'b0;
            s1_sol_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
        end else begin
            s1_valid_q <= capture;
            if (capture) begin
                s1_left_q   <= color_left;
                s1_right_q  <= color_right;
                s1_bright_q <= brightness;
                s1_blank_q  <= force_blank;
                s1_sol_q    <= pend_sol_q | line_start;
                s1_sof_q    <= pend_sof_q | frame_start;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: brightness and FIFO push
    // ------------------------------------------------------------------
    logic [31:0] push_entry;
    logic        retire;
    logic        fifo_full, fifo_empty;
    logic        push_ok, drop;

    // Entry layout: {sof, sol, left[14:0], right[14:0]}.
    assign push_entry = {s1_sof_q, s1_sol_q,
                         apply_brightness(s1_left_q, s1_bright_q, s1_blank_q),
                         apply_brightness(s1_right_q, s1_bright_q, s1_blank_q)};

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      head;
    logic [16:0]      next_hdr;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A push against a full FIFO is still accepted if the head retires in the same cycle.
    assign push_ok    = s1_valid_q && (!fifo_full || retire);
    assign drop       = s1_valid_q && fifo_full && !retire;
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    assign head       = fifo_mem[rd_ptr_q];
    assign next_hdr   = fifo_mem[rd_ptr_nxt][31:15];

    // FIFO storage. No reset: occupancy is tracked by the pointers and the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (retire)  rd_ptr_q <= rd_ptr_nxt;
            unique case ({push_ok, retire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow. A drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    ser_state_e  state_q, state_d;
    logic        valid_q, valid_d;
    logic [14:0] color_q, color_d;
    logic [8:0]  hpos_q, hpos_d, hpos_inc;
    logic        sol_q, sol_d;
    logic        sof_q, sof_d;
    logic        handshake;

    assign handshake = valid_q && out_ready;
    assign hpos_inc  = (hpos_q == HPOS_LAST) ? 9'd0 : hpos_q + 9'd1;

    // Next-state logic. Outputs change only on a handshake or when leaving idle.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        color_d = color_q;
        hpos_d  = hpos_q;
        sol_d   = sol_q;
        sof_d   = sof_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    valid_d = 1'b1;
                    color_d = head[29:15];
                    sol_d   = head[30];
                    sof_d   = head[31];
                    if (head[30]) hpos_d = 9'd0;
                    state_d = StLeft;
                end
            end
            StLeft: begin
                if (handshake) begin
                    color_d = head[14:0];
                    sol_d   = 1'b0;
                    sof_d   = 1'b0;
                    hpos_d  = hpos_inc;
                    state_d = StRight;
                end
            end
            StRight: begin
                if (handshake) begin
                    retire = 1'b1;
                    // Chain straight into the next left pixel only when it is
                    // already stored behind the retiring head.
                    if (count_q > CNT_W'(1)) begin
                        color_d = next_hdr[14:0];
                        sol_d   = next_hdr[15];
                        sof_d   = next_hdr[16];
                        hpos_d  = next_hdr[15] ? 9'd0 : hpos_inc;
                        state_d = StLeft;
                    end else begin
                        valid_d = 1'b0;
                        sol_d   = 1'b0;
                        sof_d   = 1'b0;
                        hpos_d  = hpos_inc;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // Serializer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            color_q <= 15'h0;
            hpos_q  <= 9'd0;
            sol_q   <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            color_q <= color_d;
            hpos_q  <= hpos_d;
            sol_q   <= sol_d;
            sof_q   <= sof_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_color    = color_q;
    assign out_hpos     = hpos_q;
    assign out_sol      = sol_q;
    assign out_sof      = sof_q;
    assign out_line_end = (hpos_q == HPOS_LAST);

    // ------------------------------------------------------------------
    // Optional frame CRC
    // ------------------------------------------------------------------
`ifdef PIXEL_OUT_CRC_EN
    // CRC-16-CCITT (poly 0x1021), MSB first, over one 16-bit word.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    logic [15:0] crc_run_q, frame_crc_q;

    // Running CRC. On an sof pixel, publish the previous frame and restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_run_q   <= 16'hFFFF;
            frame_crc_q <= 16'h0;
        end else if (handshake) begin
            if (sof_q) begin
                frame_crc_q <= crc_run_q;
                crc_run_q   <= crc16_word(16'hFFFF, {1'b0, color_q});
            end else begin
                crc_run_q   <= crc16_word(crc_run_q, {1'b0, color_q});
            end
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0;
`endif

endmodule

// File: tb/tb_ppu_pixel_output.sv
// Self-checking bench for ppu_pixel_output: directed and randomized dot streams
// compared against a queue-based reference model of the expected pixel stream.
module tb_ppu_pixel_output;

    localparam int LINE_PIXELS = 512;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  step;
    logic        pixel_active, line_start, frame_start;
    logic [14:0] color_left, color_right;
    logic [3:0]  brightness;
    logic        force_blank;
    logic        out_valid, out_ready;
    logic [14:0] out_color;
    logic [8:0]  out_hpos;
    logic        out_sol, out_sof, out_line_end;
    logic        overflow, overflow_clr;
    logic [15:0] frame_crc;

    ppu_pixel_output #(
        .FIFO_DEPTH  (16),
        .LINE_PIXELS (512)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .step         (step),
        .pixel_active (pixel_active),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .color_left   (color_left),
        .color_right  (color_right),
        .brightness   (brightness),
        .force_blank  (force_blank),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_color    (out_color),
        .out_hpos     (out_hpos),
        .out_sol      (out_sol),
        .out_sof      (out_sof),
        .out_line_end (out_line_end),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .frame_crc    (frame_crc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] color;
        logic        sol;
        logic        sof;
    } pix_t;

    pix_t exp_q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   hs_count = 0;
    int   le_count = 0;
    int   mdl_next_hpos = 0;
    logic mdl_pend_sol = 1'b0;
    logic mdl_pend_sof = 1'b0;
    logic rnd_ready = 1'b0;
    logic stall_prev = 1'b0;
    logic [14:0] prev_color;
    logic [8:0]  prev_hpos;
    pix_t mon_p;
    int   mon_eh;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference brightness rule with plain integer arithmetic.
    function automatic logic [14:0] bright(input logic [14:0] c, input logic [3:0] b,
                                           input logic fb);
        logic [14:0] r;
        int v;
        r = 15'h0;
        if (fb) return 15'h0;
        for (int k = 0; k < 3; k++) begin
            v = int'(c[k*5 +: 5]);
            v = (v * (int'(b) + 1)) / 16;
            r[k*5 +: 5] = 5'(v);
        end
        return r;
    endfunction

`ifdef PIXEL_OUT_CRC_EN
    logic [15:0] mdl_crc_run = 16'hFFFF;
    logic [15:0] mdl_frame_crc = 16'h0;

    function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // Stream monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (stall_prev) begin
                check_val("hold_valid", 32'(out_valid), 32'(1));
                check_val("hold_color", 32'(out_color), 32'(prev_color));
                check_val("hold_hpos", 32'(out_hpos), 32'(prev_hpos));
            end
            if (out_valid && out_ready) begin
                check_val("q_nonempty", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    mon_p  = exp_q.pop_front();
                    mon_eh = mon_p.sol ? 0 : mdl_next_hpos;
                    check_val("color", 32'(out_color), 32'(mon_p.color));
                    check_val("sol", 32'(out_sol), 32'(mon_p.sol));
                    check_val("sof", 32'(out_sof), 32'(mon_p.sof));
                    check_val("hpos", 32'(out_hpos), 32'(mon_eh));
                    check_val("line_end", 32'(out_line_end), 32'(mon_eh == LINE_PIXELS - 1));
                    mdl_next_hpos = (mon_eh + 1) % LINE_PIXELS;
`ifdef PIXEL_OUT_CRC_EN
                    if (mon_p.sof) begin
                        mdl_frame_crc = mdl_crc_run;
                        mdl_crc_run   = crc_upd(16'hFFFF, {1'b0, mon_p.color});
                    end else begin
                        mdl_crc_run = crc_upd(mdl_crc_run, {1'b0, mon_p.color});
                    end
`endif
                end
                hs_count++;
                if (out_line_end) le_count++;
            end
            stall_prev = out_valid && !out_ready;
            prev_color = out_color;
            prev_hpos  = out_hpos;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        step         = step + 2'd1;
        pixel_active = 1'b0;
        line_start   = 1'b0;
        frame_start  = 1'b0;
        overflow_clr = 1'b0;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // One dot slot: inputs presented during the step==0 cycle.
    task automatic dot(input logic act, input logic [14:0] l, input logic [14:0] r,
                       input logic [3:0] b, input logic fb, input logic ls, input logic fs,
                       input logic keep);
        pix_t t;
        while (step != 2'd0) next_cycle();
        pixel_active = act;
        color_left   = l;
        color_right  = r;
        brightness   = b;
        force_blank  = fb;
        line_start   = ls;
        frame_start  = fs;
        if (ls) mdl_pend_sol = 1'b1;
        if (fs) mdl_pend_sof = 1'b1;
        if (act) begin
            if (keep) begin
                t.color = bright(l, b, fb);
                t.sol   = mdl_pend_sol;
                t.sof   = mdl_pend_sof;
                exp_q.push_back(t);
                t.color = bright(r, b, fb);
                t.sol   = 1'b0;
                t.sof   = 1'b0;
                exp_q.push_back(t);
            end
            mdl_pend_sol = 1'b0;
            mdl_pend_sof = 1'b0;
        end
        next_cycle();
    endtask

    task automatic push_exp(input logic [14:0] c);
        pix_t t;
        t.color = c;
        t.sol   = 1'b0;
        t.sof   = 1'b0;
        exp_q.push_back(t);
    endtask

    task automatic drain();
        int i;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            next_cycle();
        end
        check_val("drain_done", 32'(i < 3000), 32'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, le0;
        reset_n = 1'b0;
        step = 2'd0;
        pixel_active = 1'b0;
        line_start = 1'b0;
        frame_start = 1'b0;
        color_left = 15'h0;
        color_right = 15'h0;
        brightness = 4'hF;
        force_blank = 1'b0;
        out_ready = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(out_valid), 32'(0));
        check_val("rst_color", 32'(out_color), 32'(0));
        check_val("rst_hpos", 32'(out_hpos), 32'(0));
        check_val("rst_sol", 32'(out_sol), 32'(0));
        check_val("rst_sof", 32'(out_sof), 32'(0));
        check_val("rst_line_end", 32'(out_line_end), 32'(0));
        check_val("rst_overflow", 32'(overflow), 32'(0));
        check_val("rst_frame_crc", 32'(frame_crc), 32'(0));
        reset_n = 1'b1;
        next_cycle();

        // Reset with three pairs buffered.
        for (int k = 0; k < 3; k++) begin
            dot(1'b1, 15'($urandom), 15'($urandom), 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        repeat (4) next_cycle();
        check_val("pre_rst_valid", 32'(out_valid), 32'(1));
        reset_n = 1'b0;
        #1;
        check_val("midrst_valid", 32'(out_valid), 32'(0));
        exp_q.delete();
        mdl_pend_sol = 1'b0;
        mdl_pend_sof = 1'b0;
        mdl_next_hpos = 0;
`ifdef PIXEL_OUT_CRC_EN
        mdl_crc_run = 16'hFFFF;
        mdl_frame_crc = 16'h0;
`endif
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        out_ready = 1'b1;
        hs0 = hs_count;
        repeat (10) dot(1'b0, 15'h0, 15'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("no_stale", 32'(hs_count), 32'(hs0));
        check_val("post_rst_valid", 32'(out_valid), 32'(0));

        // Brightness and forced blank against fixed values.
        dot(1'b1, 15'h7FFF, 15'h4210, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(15'h7FFF);
        push_exp(15'h4210);
        dot(1'b1, 15'h7FFF, 15'h0000, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(15'h3DEF);
        push_exp(15'h0000);
        dot(1'b1, 15'h7FFF, 15'h4210, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(15'h0000);
        push_exp(15'h0000);
        drain();

        // One full line of black pixels, starting a frame.
        hs0 = hs_count;
        le0 = le_count;
        dot(1'b1, 15'h0, 15'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 256; k++) begin
            dot(1'b1, 15'h0, 15'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drain();
        check_val("line_pixels", 32'(hs_count - hs0), 32'(512));
        check_val("line_end_count", 32'(le_count - le0), 32'(1));
        dot(1'b1, 15'h0, 15'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
`ifdef PIXEL_OUT_CRC_EN
        check_val("frame_crc_zero", 32'(frame_crc), 32'(mdl_frame_crc));
`else
        check_val("frame_crc_off", 32'(frame_crc), 32'(0));
`endif

        // Backpressure: 20 pairs against a 16-entry FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            dot(1'b1, 15'($urandom), 15'($urandom), 4'hF, 1'b0, 1'b0, 1'b0, k < 16);
        end
        repeat (4) next_cycle();
        check_val("bp_overflow", 32'(overflow), 32'(1));
        check_val("bp_valid", 32'(out_valid), 32'(1));
        hs0 = hs_count;
        drain();
        check_val("bp_pixels", 32'(hs_count - hs0), 32'(32));
        overflow_clr = 1'b1;
        next_cycle();
        check_val("ovf_clr", 32'(overflow), 32'(0));

        // Randomized traffic with random stalls.
        rnd_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            dot($urandom_range(0, 4) != 0, 15'($urandom), 15'($urandom), 4'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) == 0, 1'b1);
        end
        drain();
        check_val("rand_no_ovf", 32'(overflow), 32'(0));
`ifdef PIXEL_OUT_CRC_EN
        check_val("frame_crc_rand", 32'(frame_crc), 32'(mdl_frame_crc));
`else
        check_val("frame_crc_off2", 32'(frame_crc), 32'(0));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ppu_pixel_output.md
Name: ppu_pixel_output

Overview:
- Stage directly downstream of the PPU pixel mixer.
- Captures the color_left/color_right pair once per 4-cycle dot slot, applies master brightness and forced blank, and buffers pairs in a small FIFO.
- Serializes the pairs into a 512-pixel-per-line stream under valid/ready handshake toward the video output / scaler.
- Tags start-of-line and start-of-frame, and reports FIFO overflow.

Parameters:
- FIFO_DEPTH, 16, pair entries in the FIFO; power of two, 4..64.
- LINE_PIXELS, 512, output pixels per line, used for out_hpos wrap and out_line_end.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- step  input  2  PPU dot sub-step, same counter that drives the mixer
- pixel_active  input  1  current dot is a visible pixel
- line_start  input  1  pulse: next captured pair is the first of a line
- frame_start  input  1  pulse: next captured pair is the first of a frame
- color_left  input  15  mixer left/sub-pixel BGR555
- color_right  input  15  mixer right/main-pixel BGR555
- brightness  input  4  INIDISP master brightness
- force_blank  input  1  INIDISP forced blank
- out_valid  output  1  out_color valid
- out_ready  input  1  sink accepts pixel
- out_color  output  15  BGR555 output pixel
- out_hpos  output  9  pixel index within line, 0..LINE_PIXELS-1
- out_sol  output  1  current pixel is first of line
- out_sof  output  1  current pixel is first of frame
- out_line_end  output  1  out_hpos==LINE_PIXELS-1
- overflow  output  1  sticky: a pair was dropped
- overflow_clr  input  1  clears overflow
- frame_crc  output  16  CRC of previous frame, only with PIXEL_OUT_CRC_EN

Behaviour:
- Reset, async on reset_n=0:
  - FIFO empty; pending sol/sof flags cleared; hpos=0; overflow=0.
  - Outputs: out_valid=0, out_color=0, out_hpos=0, out_sol=0, out_sof=0, out_line_end=0, frame_crc=0.
  - Reset mid-line drops all buffered pixels; no partial pair is emitted afterward.
- Pending flags:
  - line_start / frame_start set pend_sol / pend_sof on any cycle.
  - The pending flag attaches to the next captured pair and clears on that capture.
  - A pulse on the same edge as a capture applies to that capture.
- Capture (S1):
  - On a posedge with step==2'h0 and pixel_active=1, latch color_left, color_right, brightness, force_blank and the pending flags.
  - step==0 is the first slot after the mixer updates its outputs at step==3.
- Brightness (S2), one cycle after S1, per 5-bit channel c:
  - force_blank=1: result 0.
  - Otherwise: result = (c*(brightness+1))>>4, computed in 9-bit intermediate.
  - brightness=15 is identity; brightness=0 gives c>>4.
- Push: S2 pushes one 32-bit entry {sof,sol,left,right} into the FIFO, one cycle after S1.
- Full / overflow:
  - If the FIFO is full and no entry retires that cycle, the pair is dropped and overflow is set.
  - Push on full with simultaneous retire is accepted.
  - overflow_clr clears overflow; a drop in the same cycle wins and leaves overflow=1.
- Serializer:
  - FSM states: IDLE, LEFT, RIGHT.
  - IDLE: when the FIFO is non-empty, present the head entry's left pixel, out_valid=1, go to LEFT.
  - LEFT: on out_valid&out_ready, present right and go to RIGHT.
  - RIGHT: on handshake, retire the head entry. If the FIFO is non-empty, present the next left in the same cycle and go to LEFT; else out_valid=0 and go to IDLE.
  - Outputs are registered and held stable while out_valid&~out_ready.
  - out_sol and out_sof are asserted on the left pixel only.
- hpos:
  - Set to 0 on the sol pixel; increments on each handshake; wraps from LINE_PIXELS-1 to 0.
  - out_line_end is combinational from the registered hpos.
- Latency: capture to out_valid is 3 cycles when the FIFO is empty.

Optional Feature:
- Macro: PIXEL_OUT_CRC_EN.
- Defined:
  - Each handshaken pixel updates a running CRC-16-CCITT (poly 0x1021, init 0xFFFF) over {1'b0,out_color}, MSB first, one pixel per cycle.
  - On a handshake of an sof pixel, frame_crc <= the running CRC before that pixel is included; the running CRC reinitializes to 0xFFFF, then includes that pixel.
- Undefined: no CRC logic; frame_crc tied to 0.

Test Plan:
- Reset mid-stream: reset_n=0 with 3 pairs buffered -> out_valid=0 next cycle, FIFO empty, no stale pixels after release.
- Brightness: left=0x7FFF, right=0x4210, brightness=15 -> 0x7FFF then 0x4210. brightness=7, left=0x7FFF -> 0x3DEF. force_blank=1 -> 0x0000, 0x0000.
- Line framing: line_start then 256 active dots, out_ready=1 -> 512 pixels; out_sol on hpos 0; out_line_end on hpos 511.
- Backpressure: out_ready=0 for 20 dot slots with FIFO_DEPTH=16 -> 16 pairs held, 4 dropped, overflow=1. After out_ready=1, exactly 32 pixels in order. overflow_clr -> overflow=0.
- Handshake stall: toggle out_ready randomly -> out_color/out_hpos stable while out_valid&~out_ready; no duplicated or skipped pixels versus the reference model.
- CRC (PIXEL_OUT_CRC_EN): frame of 512 pixels all 0x0000, then frame_start -> frame_crc equals the model CRC of 512 zero words from init 0xFFFF. Without the macro, frame_crc==0.
